// File: rtl/pc_sequencer_if.sv
// Request/response bundle between the fetch control logic and the PC sequencer.
interface pc_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              stall_i;
    logic              trap_i;
    logic [1:0]        pc_sel_i;
    logic [ADDR_W-1:0] target_i;
    logic [ADDR_W-1:0] pc_o;
    logic              ras_empty_o;
    logic              ras_full_o;
    logic              ras_ovf_o;
    logic              ras_unf_o;

    modport master (
        output stall_i, trap_i, pc_sel_i, target_i,
        input  pc_o, ras_empty_o, ras_full_o, ras_ovf_o, ras_unf_o
    );

    modport slave (
        input  stall_i, trap_i, pc_sel_i, target_i,
        output pc_o, ras_empty_o, ras_full_o, ras_ovf_o, ras_unf_o
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with trap redirect, stall and a circular return-address stack.
module pc_sequencer #(
    parameter int                 ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_VEC  = '0,
    parameter logic [ADDR_W-1:0]  TRAP_VEC   = ADDR_W'(32'h0000_0100),
    parameter int                 INST_BYTES = 4,
    parameter int                 RAS_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_sequencer_if.slave    bus
);
    localparam int ALIGN_W = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 1;
    localparam int PTR_W   = $clog2(RAS_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_CALL   = 2'b10;
    localparam logic [1:0] SEL_RET    = 2'b11;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INST_BYTES - 1);

    // Sequential successor; natural modulo-2^ADDR_W wrap of the adder.
    function automatic logic [ADDR_W-1:0] next_seq(input logic [ADDR_W-1:0] pc);
        next_seq = pc + ADDR_W'(INST_BYTES);
    endfunction

    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr);
        align_addr = addr & ALIGN_MASK;
    endfunction

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] ras_mem_r [RAS_DEPTH];
    logic [PTR_W-1:0]  top_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              empty_r;
    logic              full_r;
    logic              ovf_r;
    logic              unf_r;

    logic [ADDR_W-1:0] pc_nxt_s;
    logic [ADDR_W-1:0] seq_pc_s;
    logic [ADDR_W-1:0] push_data_s;
    logic [PTR_W-1:0]  top_nxt_s;
    logic [PTR_W-1:0]  top_dec_s;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              push_s;
    logic              ovf_set_s;
    logic              unf_set_s;
    logic              ras_full_s;
    logic              ras_nonempty_s;

    assign seq_pc_s       = next_seq(pc_r);
    assign top_dec_s      = top_r - PTR_W'(1);
    assign ras_full_s     = (cnt_r == CNT_W'(RAS_DEPTH));
    assign ras_nonempty_s = (cnt_r != CNT_W'(0));

    // Next-state selection: trap beats stall beats the pc_sel request.
    always_comb begin
        pc_nxt_s    = pc_r;
        top_nxt_s   = top_r;
        cnt_nxt_s   = cnt_r;
        push_s      = 1'b0;
        push_data_s = seq_pc_s;
        ovf_set_s   = 1'b0;
        unf_set_s   = 1'b0;
        if (bus.trap_i) begin
            pc_nxt_s  = TRAP_VEC;
            top_nxt_s = '0;
            cnt_nxt_s = '0;
        end else if (bus.stall_i) begin
            pc_nxt_s = pc_r;
        end else begin
            case (bus.pc_sel_i)
                SEL_SEQ: begin
                    pc_nxt_s = seq_pc_s;
                end
                SEL_BRANCH: begin
                    pc_nxt_s = align_addr(bus.target_i);
                end
                SEL_CALL: begin
                    // top_r is the next free slot; when full it is also the oldest entry.
                    pc_nxt_s  = align_addr(bus.target_i);
                    push_s    = 1'b1;
                    top_nxt_s = top_r + PTR_W'(1);
                    if (ras_full_s) begin
                        ovf_set_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end
                SEL_RET: begin
                    if (ras_nonempty_s) begin
                        pc_nxt_s  = ras_mem_r[top_dec_s];
                        top_nxt_s = top_dec_s;
                        cnt_nxt_s = cnt_r - CNT_W'(1);
                    end else begin
                        pc_nxt_s  = seq_pc_s;
                        unf_set_s = 1'b1;
                    end
                end
                default: begin
                    pc_nxt_s = pc_r;
                end
            endcase
        end
    end

    // Architectural state and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r    <= RESET_VEC;
            top_r   <= '0;
            cnt_r   <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            pc_r    <= pc_nxt_s;
            top_r   <= top_nxt_s;
            cnt_r   <= cnt_nxt_s;
            empty_r <= (cnt_nxt_s == CNT_W'(0));
            full_r  <= (cnt_nxt_s == CNT_W'(RAS_DEPTH));
            ovf_r   <= ovf_r | ovf_set_s;
            unf_r   <= unf_r | unf_set_s;
        end
    end

    // Return-address storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            ras_mem_r[top_r] <= push_data_s;
        end else begin
            ras_mem_r[top_r] <= ras_mem_r[top_r];
        end
    end

    assign bus.pc_o        = pc_r;
    assign bus.ras_empty_o = empty_r;
    assign bus.ras_full_o  = full_r;
    assign bus.ras_ovf_o   = ovf_r;
    assign bus.ras_unf_o   = unf_r;
endmodule
